// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: FSM encoding,
// requester count and the round-robin search used for every grant decision.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // First requesting index strictly after ptr, wrapping; ptr itself is the
  // last candidate so a lone requester is re-granted.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr,
                                               input logic [NUM_REQ-1:0] req);
    logic [SEL_W-1:0] idx;
    rr_next = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) rr_next = idx;
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    to_onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_w.sv
// WIDTH-bit 4:1 data mux built from three 2:1 stages.
module mux4_w #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  assign lo = sel[0] ? d1 : d0;
  assign hi = sel[0] ? d3 : d2;
  assign y  = sel[1] ? hi : lo;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux, bursts of up to
// MAX_BURST beats. Define MUX4_ARB_PREEMPT_EN to let requester 0 preempt.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             out_ready,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  state_e           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [SEL_W-1:0] last_ptr;

  logic             transfer;
  logic             last_beat;
  logic             preempt;
  logic             burst_end;
  logic [SEL_W-1:0] pick_idx;

  mux4_w #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .d0  (din0),
    .d1  (din1),
    .d2  (din2),
    .d3  (din3),
    .y   (dout)
  );

  assign out_valid = grant[sel] & req[sel];
  assign busy      = (state == ST_BUSY);
  assign transfer  = out_valid & out_ready;
  assign last_beat = transfer && (beat_cnt == CNT_W'(MAX_BURST - 1));

`ifdef MUX4_ARB_PREEMPT_EN
  // A stalled beat is allowed to complete before requester 0 takes over.
  assign preempt = req[0] && (sel != '0) && (transfer || !out_valid);
`else
  assign preempt = 1'b0;
`endif

  assign burst_end = last_beat || !req[sel] || preempt;

  always_comb begin
    pick_idx = '0;
    if (state == ST_IDLE) pick_idx = rr_next(last_ptr, req);
    else if (!preempt)    pick_idx = rr_next(sel, req);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      sel      <= '0;
      beat_cnt <= '0;
      last_ptr <= SEL_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (|req) begin
            state <= ST_BUSY;
            grant <= to_onehot(pick_idx);
            sel   <= pick_idx;
          end
        end
        ST_BUSY: begin
          if (burst_end) begin
            last_ptr <= sel;
            beat_cnt <= '0;
            if (|req) begin
              grant <= to_onehot(pick_idx);
              sel   <= pick_idx;
            end else begin
              state <= ST_IDLE;
              grant <= '0;
            end
          end else if (transfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (WIDTH=8, MAX_BURST=4); expectations are
// hand-derived, with the preemption case following MUX4_ARB_PREEMPT_EN.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] din0, din1, din2, din3;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [7:0] dout;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .dout      (dout),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] din_of(input int i);
    case (i)
      0: din_of = 8'hA0;
      1: din_of = 8'hB1;
      2: din_of = 8'hC2;
      default: din_of = 8'hD3;
    endcase
  endfunction

  initial begin
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    din0 = 8'hA0; din1 = 8'hB1; din2 = 8'hC2; din3 = 8'hD3;

    // Reset held with all requesting
    tick(); tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sel", sel, 2'd0);

    rst = 1'b0;
    #1;
    check("rel_grant_pre", grant, 4'b0000);
    tick();
    check("first_grant", grant, 4'b0001);
    check("first_valid", out_valid, 1'b1);
    check("first_busy", busy, 1'b1);

    // All four requesting: 4 beats each, order 0,1,2,3 with no bubble
    for (int n = 0; n < 16; n++) begin
      check("rr_grant", grant, 4'b0001 << (n / 4));
      check("rr_sel", sel, n / 4);
      check("rr_dout", dout, din_of(n / 4));
      check("rr_valid", out_valid, 1'b1);
      tick();
    end
    check("rr_wrap", grant, 4'b0001);

    // Only requester 1: continuous re-grant across burst boundaries
    req = 4'b0010;
    #1;
    check("drop0_valid", out_valid, 1'b0);
    tick();
    for (int n = 0; n < 10; n++) begin
      check("solo_grant", grant, 4'b0010);
      check("solo_valid", out_valid, 1'b1);
      tick();
    end

    // Grant 2, one beat, then a 5-cycle stall
    req = 4'b0100;
    tick();
    check("g2_grant", grant, 4'b0100);
    tick();
    out_ready = 1'b0; din2 = 8'h5C;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("stall_grant", grant, 4'b0100);
      check("stall_sel", sel, 2'd2);
      check("stall_dout", dout, 8'h5C);
      check("stall_valid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1; din2 = 8'hC2; req = 4'b1100;
    tick();
    check("post_stall_b2", grant, 4'b0100);
    tick();
    check("post_stall_b3", grant, 4'b0100);
    tick();
    check("post_stall_next", grant, 4'b1000);

    // Grant 0, two beats, then requester 0 drops
    req = 4'b0001;
    tick();
    check("g0_grant", grant, 4'b0001);
    req = 4'b1011;
    tick(); tick();
    req = 4'b1010;
    #1;
    check("drop_valid", out_valid, 1'b0);
    tick();
    check("drop_next", grant, 4'b0010);
    for (int n = 0; n < 4; n++) begin
      check("drop_burst1", grant, 4'b0010);
      tick();
    end
    check("drop_then3", grant, 4'b1000);

    // Requester 0 rises during beat 1 of requester 2's burst
    req = 4'b0100;
    tick();
    check("pre_g2", grant, 4'b0100);
    tick();
    req = 4'b1101;
    tick();
`ifdef MUX4_ARB_PREEMPT_EN
    check("preempt_g0", grant, 4'b0001);
`else
    check("nopre_b2", grant, 4'b0100);
    tick();
    check("nopre_b3", grant, 4'b0100);
    tick();
    check("nopre_g3", grant, 4'b1000);
    tick(); tick(); tick(); tick();
    check("nopre_g0", grant, 4'b0001);
`endif

    // All requests removed -> idle
    req = 4'b0000;
    #1;
    check("idle_valid", out_valid, 1'b0);
    tick();
    check("idle_grant", grant, 4'b0000);
    check("idle_busy", busy, 1'b0);

    // Async reset mid-burst drops grant without waiting for an edge
    req = 4'b0010;
    tick();
    check("pre_rst_grant", grant, 4'b0010);
    #2 rst = 1'b1;
    #1;
    check("async_grant", grant, 4'b0000);
    check("async_valid", out_valid, 1'b0);
    check("async_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("after_rst_grant", grant, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
